// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronised inputs, per-bit edge capture (W1C) and a
// maskable level interrupt. Edge detection stays off until the synchroniser is primed.
module pio_in_edge_irq #(
   parameter int WIDTH       = 4,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int PRIME_MAX = SYNC_STAGES + 1;

   logic [WIDTH-1:0] sync_stage_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_stage_d [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0] edge_raw, edge_det, w1c_bits;
   logic [2:0]       prime_cnt_q, prime_cnt_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   logic             primed, wr_en;
   logic             unused_wd;

   assign sync_q    = sync_stage_q[SYNC_STAGES-1];
   assign readdata  = readdata_q;
   assign irq       = irq_q;
   assign wr_en     = chipselect && !write_n;
   assign unused_wd = ^writedata;

   always_comb begin
      sync_stage_d[0] = in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_stage_d[i] = sync_stage_q[i-1];
      end
   end

   assign prev_d      = sync_q;
   assign primed      = (prime_cnt_q == 3'(PRIME_MAX));
   assign prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 3'd1;

   always_comb begin
      case (EDGE_TYPE)
         0:       edge_raw = sync_q & ~prev_q;
         1:       edge_raw = ~sync_q & prev_q;
         default: edge_raw = sync_q ^ prev_q;
      endcase
      edge_det = primed ? edge_raw : '0;
   end

   // A capture in the same cycle as its W1C wins, so no edge is ever lost.
   always_comb begin
      w1c_bits   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
      edge_cap_d = (edge_cap_q & ~w1c_bits) | edge_det;
      irq_mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask_q;
      irq_d      = |(edge_cap_q & irq_mask_q);
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         2'd0:    readdata_d[WIDTH-1:0] = sync_q;
         2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
         2'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
         default: readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_stage_q[i] <= '0;
         end
         prev_q      <= '0;
         prime_cnt_q <= '0;
         irq_mask_q  <= '0;
         edge_cap_q  <= '0;
         readdata_q  <= '0;
         irq_q       <= 1'b0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_stage_q[i] <= sync_stage_d[i];
         end
         prev_q      <= prev_d;
         prime_cnt_q <= prime_cnt_d;
         irq_mask_q  <= irq_mask_d;
         edge_cap_q  <= edge_cap_d;
         readdata_q  <= readdata_d;
         irq_q       <= irq_d;
      end
   end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: default instance against a sample-history model,
// plus a 32-bit any-edge instance with a deeper synchroniser checked directly.
module tb_pio_in_edge_irq;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect, write_n;
   logic [31:0] writedata, readdata;
   logic [3:0]  in_port;
   logic        irq;

   logic [1:0]  a2;
   logic        cs2, wn2;
   logic [31:0] wd2, rd2, in2;
   logic        irq2;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pio_in_edge_irq dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .irq(irq)
   );

   pio_in_edge_irq #(.WIDTH(32), .EDGE_TYPE(2), .SYNC_STAGES(3)) dut2 (
      .clk(clk), .reset_n(reset_n), .address(a2), .chipselect(cs2),
      .write_n(wn2), .writedata(wd2), .readdata(rd2),
      .in_port(in2), .irq(irq2)
   );

   // Reference: in_port history (newest first); sync = value seen S-1 edges ago.
   logic [3:0]  m_samp [$];
   int          m_edges;
   logic [3:0]  m_mask, m_cap;
   logic        m_irq;
   logic [31:0] m_rd;

   task automatic model_reset();
      m_samp  = {4'h0, 4'h0, 4'h0};
      m_edges = 0;
      m_mask  = 4'h0;
      m_cap   = 4'h0;
      m_irq   = 1'b0;
      m_rd    = 32'h0;
   endtask

   task automatic model_edge();
      logic [3:0] sync, prev, det, clr;
      sync = m_samp[S-1];
      prev = m_samp[S];
      det  = (m_edges >= S + 1) ? (sync & ~prev) : 4'h0;
      clr  = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
      case (address)
         2'd0:    m_rd = {28'h0, sync};
         2'd2:    m_rd = {28'h0, m_mask};
         2'd3:    m_rd = {28'h0, m_cap};
         default: m_rd = 32'h0;
      endcase
      m_irq = (m_cap & m_mask) != 4'h0;
      m_cap = (m_cap & ~clr) | det;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
      m_samp.push_front(in_port);
      void'(m_samp.pop_back());
      if (m_edges < S + 1) m_edges++;
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (reset_n) model_edge();
      end
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      step();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic do_write2(input logic [1:0] a, input logic [31:0] d);
      a2 = a; wd2 = d; cs2 = 1'b1; wn2 = 1'b0;
      step();
      cs2 = 1'b0; wn2 = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'h0; in_port = 4'hF;
      a2 = 2'd0; cs2 = 1'b0; wn2 = 1'b1; wd2 = 32'h0; in2 = 32'h0;
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: readdata=%h irq=%b required 0/0", readdata, irq);
      end
      step(3);
      reset_n = 1'b1;
      address = 2'd3;
      step(10);
      n_cmp++;
      if (readdata !== 32'h0 || irq !== 1'b0 || readdata !== m_rd) begin
         n_fail++;
         $display("FAIL reset_cap: readdata=%h irq=%b required 0/0", readdata, irq);
      end
      address = 2'd0;
      step();
      n_cmp++;
      if (readdata !== 32'h0000000F) begin
         n_fail++;
         $display("FAIL reset_data: readdata=%h required 0000000f", readdata);
      end
   endtask

   task automatic test_rising();
      in_port = 4'h0;
      step(4);
      do_write(2'd2, 32'h4);
      in_port = 4'h4;
      address = 2'd3;
      step(3);
      n_cmp++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL rise_irq_early: irq=%b required 0", irq);
      end
      step();
      n_cmp++;
      if (irq !== 1'b1 || readdata !== 32'h4) begin
         n_fail++;
         $display("FAIL rise_capture: irq=%b readdata=%h required 1/4", irq, readdata);
      end
      do_write(2'd3, 32'h4);
      n_cmp++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL w1c_irq_hold: irq=%b required 1", irq);
      end
      step();
      n_cmp++;
      if (irq !== 1'b0 || readdata !== 32'h0) begin
         n_fail++;
         $display("FAIL w1c_clear: irq=%b readdata=%h required 0/0", irq, readdata);
      end
   endtask

   task automatic test_set_clear_collision();
      do_write(2'd2, 32'h2);
      in_port = 4'h6;
      step(5);
      n_cmp++;
      if (irq !== 1'b1 || readdata !== 32'h2) begin
         n_fail++;
         $display("FAIL coll_setup: irq=%b readdata=%h required 1/2", irq, readdata);
      end
      in_port = 4'h4;
      step(4);
      in_port = 4'h6;
      step(2);
      do_write(2'd3, 32'h2);
      step();
      n_cmp++;
      if (irq !== 1'b1 || readdata !== 32'h2) begin
         n_fail++;
         $display("FAIL coll_set_wins: irq=%b readdata=%h required 1/2", irq, readdata);
      end
   endtask

   task automatic test_masking();
      do_write(2'd2, 32'h0);
      do_write(2'd3, 32'hF);
      in_port = 4'h4;
      step(4);
      do_write(2'd3, 32'hF);
      in_port = 4'h7;
      step(5);
      n_cmp++;
      if (irq !== 1'b0 || readdata !== 32'h3) begin
         n_fail++;
         $display("FAIL mask_off: irq=%b readdata=%h required 0/3", irq, readdata);
      end
      do_write(2'd2, 32'h2);
      n_cmp++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL mask_latency: irq=%b required 0", irq);
      end
      step();
      n_cmp++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL mask_on: irq=%b required 1", irq);
      end
      do_write(2'd1, 32'hFFFF_FFFF);
      address = 2'd1;
      step();
      n_cmp++;
      if (readdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reserved_read: readdata=%h required 0", readdata);
      end
      address = 2'd2;
      step();
      n_cmp++;
      if (readdata !== 32'h2) begin
         n_fail++;
         $display("FAIL mask_readback: readdata=%h required 2", readdata);
      end
   endtask

   task automatic test_any_edge_wide();
      do_write2(2'd2, 32'h8000_0000);
      in2 = 32'h8000_0000;
      a2  = 2'd3;
      step(8);
      n_cmp++;
      if (rd2 !== 32'h8000_0000 || irq2 !== 1'b1) begin
         n_fail++;
         $display("FAIL any_rise: readdata=%h irq=%b required 80000000/1", rd2, irq2);
      end
      a2 = 2'd0;
      step();
      n_cmp++;
      if (rd2 !== 32'h8000_0000) begin
         n_fail++;
         $display("FAIL wide_data: readdata=%h required 80000000", rd2);
      end
      do_write2(2'd3, 32'h8000_0000);
      step(2);
      n_cmp++;
      if (rd2 !== 32'h0 || irq2 !== 1'b0) begin
         n_fail++;
         $display("FAIL any_clear: readdata=%h irq=%b required 0/0", rd2, irq2);
      end
      in2 = 32'h0;
      step(8);
      n_cmp++;
      if (rd2 !== 32'h8000_0000 || irq2 !== 1'b1) begin
         n_fail++;
         $display("FAIL any_fall: readdata=%h irq=%b required 80000000/1", rd2, irq2);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         int r;
         if ($urandom_range(0, 2) == 0) in_port = 4'($urandom_range(0, 15));
         r = $urandom_range(0, 9);
         address    = 2'($urandom_range(0, 3));
         writedata  = $urandom;
         chipselect = $urandom_range(0, 1) == 1;
         write_n    = 1'b1;
         if (r == 0) begin
            address = 2'd2; chipselect = 1'b1; write_n = 1'b0;
         end else if (r <= 2) begin
            address = 2'd3; chipselect = 1'b1; write_n = 1'b0;
         end else if (r == 3) begin
            chipselect = 1'b1; write_n = 1'b0;
         end
         step();
         chipselect = 1'b0; write_n = 1'b1;
         n_cmp++;
         if (readdata !== m_rd || irq !== m_irq) begin
            n_fail++;
            $display("FAIL random[%0d]: readdata=%h irq=%b required %h/%b",
                     c, readdata, irq, m_rd, m_irq);
         end
      end
   endtask

   task automatic test_mid_reset();
      do_write(2'd3, 32'hF);
      do_write(2'd2, 32'h9);
      in_port = 4'h6;
      step(4);
      do_write(2'd3, 32'hF);
      in_port = 4'hF;
      step(5);
      n_cmp++;
      if (readdata !== 32'h9 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_setup: readdata=%h irq=%b required 9/1", readdata, irq);
      end
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (readdata !== 32'h0 || irq !== 1'b0 || rd2 !== 32'h0 || irq2 !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_async: readdata=%h irq=%b required 0/0", readdata, irq);
      end
      #3 reset_n = 1'b1;
      #1;
      n_cmp++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_release: readdata=%h irq=%b required 0/0", readdata, irq);
      end
      address = 2'd3;
      step(10);
      n_cmp++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_prime: readdata=%h irq=%b required 0/0", readdata, irq);
      end
      address = 2'd2;
      step();
      n_cmp++;
      if (readdata !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_mask: readdata=%h required 0", readdata);
      end
   endtask

   initial begin
      test_reset();
      test_rising();
      test_set_clear_collision();
      test_masking();
      test_any_edge_wide();
      test_random();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
